// File: rtl/ct_spsram_acc_pkg.sv
// Shared widths, response-queue depth and controller state encoding for the
// 256x7 single-port SRAM access controller.
package ct_spsram_acc_pkg;

  localparam int ADDR_W     = 8;
  localparam int DATA_W     = 7;
  localparam int RSPQ_DEPTH = 2;
  localparam int RSPQ_CNT_W = 2;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/ct_spsram_acc_rspq.sv
// Two-entry read-response FIFO with valid/ready on both sides; the head entry
// is held stable until it is popped.
module ct_spsram_acc_rspq
  import ct_spsram_acc_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_push_vld,
  output logic                  o_push_rdy,
  input  logic [DATA_W-1:0]     i_push_data,
  output logic                  o_pop_vld,
  input  logic                  i_pop_rdy,
  output logic [DATA_W-1:0]     o_pop_data,
  output logic [RSPQ_CNT_W-1:0] o_count
);

  logic [DATA_W-1:0]     r_mem [RSPQ_DEPTH];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [RSPQ_CNT_W-1:0] r_count;
  logic                  w_push;
  logic                  w_pop;

  assign o_push_rdy = (r_count != RSPQ_CNT_W'(RSPQ_DEPTH));
  assign o_pop_vld  = (r_count != '0);
  assign w_push     = i_push_vld && o_push_rdy;
  assign w_pop      = o_pop_vld && i_pop_rdy;
  assign o_pop_data = r_mem[r_rd_ptr];
  assign o_count    = r_count;

  // NOTE: the storage array is deliberately left out of reset; only the
  // pointers and count decide what is valid, so resetting data buys nothing.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/ct_spsram_256x7_acc.sv
// Access controller for an external 256x7 single-port SRAM macro: optional
// clear sweep after reset, masked writes, and 2-cycle-latency ordered reads.
module ct_spsram_256x7_acc
  import ct_spsram_acc_pkg::*;
#(
  parameter bit                INIT_EN  = 1'b1,
  parameter logic [DATA_W-1:0] INIT_VAL = 7'h00
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_vld,
  output logic              req_rdy,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [DATA_W-1:0] req_wmask,
  output logic              rsp_vld,
  input  logic              rsp_rdy,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              init_done,
  output logic [ADDR_W-1:0] sram_a,
  output logic              sram_cen,
  output logic              sram_gwen,
  output logic [DATA_W-1:0] sram_wen,
  output logic [DATA_W-1:0] sram_d,
  input  logic [DATA_W-1:0] sram_q
);

  state_e                r_state;
  state_e                w_state_nxt;
  logic [ADDR_W-1:0]     r_sweep_addr;
  logic                  r_init_done;
  logic                  r_rd_pend;
  logic                  w_run;
  logic                  w_accept;
  logic                  w_rd_accept;
  logic                  w_rd_cap;
  logic                  w_q_vld;
  logic                  w_q_space;
  logic                  w_pop;
  logic [RSPQ_CNT_W-1:0] w_q_count;
  logic [RSPQ_CNT_W:0]   w_fill;

  // A pop this cycle frees a slot in time for a read accepted now, which is
  // what lets streaming reads run at one per cycle through a 2-deep queue.
  assign w_fill = {1'b0, w_q_count} + {{RSPQ_CNT_W{1'b0}}, r_rd_pend}
                - {{RSPQ_CNT_W{1'b0}}, w_pop};
  assign w_rd_cap    = (w_fill < (RSPQ_CNT_W+1)'(RSPQ_DEPTH));
  assign w_run       = (r_state == ST_RUN) && !RST;
  assign req_rdy     = w_run && ((req_vld && req_wr) || w_rd_cap);
  assign w_accept    = req_vld && req_rdy;
  assign w_rd_accept = w_accept && !req_wr;
  assign rsp_vld     = w_q_vld && !RST;
  assign w_pop       = rsp_vld && rsp_rdy;
  assign init_done   = INIT_EN ? (r_init_done && !RST) : 1'b1;

  // Outputs are gated by RST so the macro sees no access while reset is held.
  always_comb begin
    w_state_nxt = r_state;
    sram_cen    = 1'b1;
    sram_gwen   = 1'b1;
    sram_wen    = '1;
    sram_a      = req_addr;
    sram_d      = req_wdata;
    if (r_state == ST_INIT && r_sweep_addr == '1) w_state_nxt = ST_RUN;
    if (!RST) begin
      if (r_state == ST_INIT) begin
        sram_cen  = 1'b0;
        sram_gwen = 1'b0;
        sram_wen  = '0;
        sram_a    = r_sweep_addr;
        sram_d    = INIT_VAL;
      end else if (w_accept) begin
        sram_cen  = 1'b0;
        sram_gwen = !req_wr;
        sram_wen  = req_wr ? ~req_wmask : '1;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= INIT_EN ? ST_INIT : ST_RUN;
      r_sweep_addr <= '0;
      r_init_done  <= !INIT_EN;
      r_rd_pend    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_rd_pend <= w_rd_accept;
      if (r_state == ST_INIT) r_sweep_addr <= r_sweep_addr + 8'd1;
      if (r_state == ST_INIT && w_state_nxt == ST_RUN) r_init_done <= 1'b1;
    end
  end

  ct_spsram_acc_rspq u_rspq (
    .i_clk       (CLK),
    .i_rst       (RST),
    .i_push_vld  (r_rd_pend),
    .o_push_rdy  (w_q_space),
    .i_push_data (sram_q),
    .o_pop_vld   (w_q_vld),
    .i_pop_rdy   (rsp_rdy && !RST),
    .o_pop_data  (rsp_rdata),
    .o_count     (w_q_count)
  );

  a_no_push_overflow: assert property (@(posedge CLK) disable iff (RST)
    r_rd_pend |-> w_q_space);

endmodule

// File: tb/tb_ct_spsram_256x7_acc.sv
// Self-checking bench: behavioural SRAM macro, array/queue reference model of
// the memory and response ordering, directed scenarios plus random traffic.
module tb_ct_spsram_256x7_acc;

  logic       CLK = 1'b0;
  logic       RST;
  logic       req_vld, req_rdy, req_wr;
  logic [7:0] req_addr;
  logic [6:0] req_wdata, req_wmask;
  logic       rsp_vld, rsp_rdy;
  logic [6:0] rsp_rdata;
  logic       init_done;
  logic [7:0] sram_a;
  logic       sram_cen, sram_gwen;
  logic [6:0] sram_wen, sram_d, sram_q;

  always #5 CLK = ~CLK;

  ct_spsram_256x7_acc dut (
    .CLK(CLK), .RST(RST),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_wmask(req_wmask),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_rdata(rsp_rdata),
    .init_done(init_done),
    .sram_a(sram_a), .sram_cen(sram_cen), .sram_gwen(sram_gwen),
    .sram_wen(sram_wen), .sram_d(sram_d), .sram_q(sram_q)
  );

  // Behavioural macro: bit-masked write, registered read data.
  logic [6:0] mac_mem [256];
  logic [6:0] mac_q;
  assign sram_q = mac_q;
  always @(posedge CLK) begin
    if (!sram_cen) begin
      if (!sram_gwen) begin
        for (int b = 0; b < 7; b++)
          if (!sram_wen[b]) mac_mem[sram_a][b] <= sram_d[b];
      end else begin
        mac_q <= mac_mem[sram_a];
      end
    end
  end

  // Reference model: memory image plus queue of expected read data.
  logic [6:0] ref_mem [256];
  logic [6:0] exp_q [$];

  int vectors = 0;
  int miscompares = 0;
  int cyc_n = 0;

  logic       s_cen, s_gwen, s_req_rdy, s_rsp_vld, s_init_done, s_accept, s_pop;
  logic [6:0] s_wen, s_d, s_rdata, prev_rdata, last_pop_data;
  logic [7:0] s_a;
  logic       prev_stall = 1'b0;
  int         n_pop, first_pop_cyc, last_pop_cyc, n_vld;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic vld, input logic wr, input logic [7:0] addr,
                       input logic [6:0] wdata, input logic [6:0] wmask, input logic rrdy);
    req_vld = vld; req_wr = wr; req_addr = addr;
    req_wdata = wdata; req_wmask = wmask; rsp_rdy = rrdy;
  endtask

  // One clock: sample at the falling edge, update the model, step past posedge.
  task automatic tick();
    @(negedge CLK);
    s_cen = sram_cen; s_gwen = sram_gwen; s_wen = sram_wen; s_a = sram_a; s_d = sram_d;
    s_req_rdy = req_rdy; s_rsp_vld = rsp_vld; s_rdata = rsp_rdata; s_init_done = init_done;
    s_accept = req_vld && req_rdy;
    s_pop = rsp_vld && rsp_rdy;
    if (s_rsp_vld) n_vld++;
    if (RST) begin
      exp_q.delete();
    end else begin
      if (prev_stall && s_rsp_vld) check("rsp_stable", 32'(s_rdata), 32'(prev_rdata));
      if (s_pop) begin
        check("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("rsp_data", 32'(s_rdata), 32'(exp_q.pop_front()));
        last_pop_data = s_rdata;
        if (n_pop == 0) first_pop_cyc = cyc_n;
        last_pop_cyc = cyc_n;
        n_pop++;
      end
      if (s_accept) begin
        if (req_wr) ref_mem[req_addr] = (ref_mem[req_addr] & ~req_wmask) | (req_wdata & req_wmask);
        else        exp_q.push_back(ref_mem[req_addr]);
      end
    end
    prev_stall = s_rsp_vld && !rsp_rdy && !RST;
    prev_rdata = s_rdata;
    cyc_n++;
    @(posedge CLK);
    #1;
  endtask

  task automatic sweep_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      check("sweep_port", {8'h0, s_cen, s_gwen, s_wen, s_a, s_d},
            {8'h0, 1'b0, 1'b0, 7'h00, 8'(i), 7'h00});
      if (i == 255) check("init_done_low_last_sweep", 32'(s_init_done), 32'd0);
    end
  endtask

  task automatic full_sweep();
    sweep_cycles(256);
    tick();
    check("init_done_after_sweep", 32'(s_init_done), 32'd1);
    check("req_rdy_after_sweep", 32'(s_req_rdy), 32'd1);
    for (int i = 0; i < 256; i++) ref_mem[i] = 7'h00;
  endtask

  task automatic drain();
    drive(1'b0, 1'b0, 8'h00, 7'h00, 7'h00, 1'b1);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int acc, first_acc;
    logic [7:0] rd_addrs [4];
    n_pop = 0; n_vld = 0; first_pop_cyc = 0; last_pop_cyc = 0;
    RST = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 7'h00, 7'h00, 1'b0);
    @(posedge CLK); #1;

    // Outputs while reset is held
    for (int k = 0; k < 2; k++) begin
      tick();
      check("rst_port_idle", {23'h0, s_cen, s_gwen, s_wen}, {23'h0, 1'b1, 1'b1, 7'h7F});
      check("rst_hs", {29'h0, s_req_rdy, s_rsp_vld, s_init_done}, 32'd0);
    end

    // Clear sweep, then cleared contents are read back
    RST = 1'b0;
    full_sweep();
    drive(1'b1, 1'b0, 8'hA5, 7'h00, 7'h00, 1'b1);
    tick();
    drain();
    check("read_cleared_A5", 32'(last_pop_data), 32'h00);

    // Write then read the same address next cycle; latency 2
    drive(1'b1, 1'b1, 8'h10, 7'h2A, 7'h7F, 1'b1);
    tick();
    check("wr_accept", 32'(s_accept), 32'd1);
    drive(1'b1, 1'b0, 8'h10, 7'h00, 7'h00, 1'b1);
    tick();
    check("rd_accept", 32'(s_accept), 32'd1);
    drive(1'b0, 1'b0, 8'h00, 7'h00, 7'h00, 1'b1);
    tick();
    check("rsp_vld_n1", 32'(s_rsp_vld), 32'd0);
    tick();
    check("rsp_vld_n2", 32'(s_rsp_vld), 32'd1);
    check("raw_data", 32'(s_rdata), 32'h2A);

    // Masked write keeps unmasked-off bits
    drive(1'b1, 1'b1, 8'h20, 7'h7F, 7'h7F, 1'b1); tick();
    drive(1'b1, 1'b1, 8'h20, 7'h00, 7'h0F, 1'b1); tick();
    drive(1'b1, 1'b0, 8'h20, 7'h00, 7'h00, 1'b1); tick();
    drain();
    check("masked_write", 32'(last_pop_data), 32'h70);

    // Backpressure: only two reads fit, writes still accepted
    rd_addrs[0] = 8'h10; rd_addrs[1] = 8'h20; rd_addrs[2] = 8'h30; rd_addrs[3] = 8'h40;
    acc = 0;
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 1'b0, rd_addrs[k], 7'h00, 7'h00, 1'b0);
      tick();
      if (s_accept) acc++;
    end
    check("bp_reads_accepted", 32'(acc), 32'd2);
    drive(1'b0, 1'b0, 8'h00, 7'h00, 7'h00, 1'b0); tick();
    check("bp_rdy_idle", 32'(s_req_rdy), 32'd0);
    check("bp_rsp_held", 32'(s_rsp_vld), 32'd1);
    drive(1'b1, 1'b1, 8'h30, 7'h15, 7'h7F, 1'b0); tick();
    check("bp_write_accepted", 32'(s_accept), 32'd1);
    n_pop = 0;
    drain();
    check("bp_pops", 32'(n_pop), 32'd2);

    // Streaming reads at one per cycle
    n_pop = 0; acc = 0; first_acc = 0;
    for (int k = 0; k < 16; k++) begin
      drive(1'b1, 1'b0, 8'(k), 7'h00, 7'h00, 1'b1);
      tick();
      if (s_accept) begin
        if (acc == 0) first_acc = cyc_n - 1;
        acc++;
      end
    end
    drain();
    check("stream_accepts", 32'(acc), 32'd16);
    check("stream_pops", 32'(n_pop), 32'd16);
    check("stream_first_lat", 32'(first_pop_cyc - first_acc), 32'd2);
    check("stream_span", 32'(last_pop_cyc - first_pop_cyc), 32'd15);

    // Random traffic against the reference model
    for (int k = 0; k < 400; k++) begin
      drive($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 31)),
            7'($urandom), 7'($urandom), $urandom_range(0, 3) != 0);
      tick();
    end
    drain();

    // Reset with a read in flight, then reset mid-sweep
    drive(1'b1, 1'b0, 8'h05, 7'h00, 7'h00, 1'b1);
    tick();
    check("inflight_rd_accept", 32'(s_accept), 32'd1);
    RST = 1'b1;
    drive(1'b0, 1'b0, 8'h00, 7'h00, 7'h00, 1'b1);
    n_vld = 0;
    tick();
    check("rst_inflight_idle", {23'h0, s_cen, s_gwen, s_wen}, {23'h0, 1'b1, 1'b1, 7'h7F});
    tick();
    RST = 1'b0;
    sweep_cycles(128);
    RST = 1'b1;
    tick();
    check("rst_mid_sweep_idle", {23'h0, s_cen, s_gwen, s_wen}, {23'h0, 1'b1, 1'b1, 7'h7F});
    check("rst_mid_sweep_init_done", 32'(s_init_done), 32'd0);
    RST = 1'b0;
    full_sweep();
    check("no_rsp_after_rst", 32'(n_vld), 32'd0);
    drive(1'b1, 1'b0, 8'h10, 7'h00, 7'h00, 1'b1);
    tick();
    drain();
    check("read_after_resweep", 32'(last_pop_data), 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
